// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: collects functional-unit results into small per-source
// FIFOs and drives up to NUM_WRITE_PORTS register-file writes per cycle,
// granted round-robin across sources. Two results aimed at the same physical
// register are never written in the same cycle; the later one waits.
// Optional macro REG_WB_BYPASS_EN: an incoming result whose source FIFO is
// empty may be granted in its handshake cycle instead of being buffered.

package reg_pkg;
   localparam int WORD_SIZE     = 32;
   localparam int NUM_PHYS_REGS = 64;
   localparam int IDX_W         = $clog2(NUM_PHYS_REGS);

   typedef struct packed {
      logic                 en;
      logic [IDX_W-1:0]     index_in;
      logic [WORD_SIZE-1:0] data_in;
   } RegFileWritePort;
endpackage

// Per-source result FIFO: registered count, wrapping read/write pointers.
module reg_wb_src_fifo #(
   parameter int IDX_W     = 6,
   parameter int WORD_SIZE = 32,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [IDX_W-1:0]     push_idx,
   input  logic [WORD_SIZE-1:0] push_data,
   input  logic                 pop,
   output logic                 empty,
   output logic                 full,
   output logic [IDX_W-1:0]     head_idx,
   output logic [WORD_SIZE-1:0] head_data
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0][IDX_W-1:0]     idx_mem_q, idx_mem_d;
   logic [DEPTH-1:0][WORD_SIZE-1:0] data_mem_q, data_mem_d;
   logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            push_ok, pop_ok;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == FULL_CNT);
   assign head_idx  = idx_mem_q[rd_ptr_q];
   assign head_data = data_mem_q[rd_ptr_q];

   // Guard against overflow/underflow even if the parent misbehaves.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Next-state: write at tail, advance head, count tracks push minus pop.
   always_comb begin
      idx_mem_d  = idx_mem_q;
      data_mem_d = data_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      if (push_ok) begin
         idx_mem_d[wr_ptr_q]  = push_idx;
         data_mem_d[wr_ptr_q] = push_data;
         wr_ptr_d             = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO state; reset discards everything buffered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_mem_q  <= '0;
         data_mem_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         idx_mem_q  <= idx_mem_d;
         data_mem_q <= data_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end
endmodule

// Top: source FIFOs, round-robin grant, register-file write port drive.
module reg_writeback_arbiter #(
   parameter int WORD_SIZE       = reg_pkg::WORD_SIZE,
   parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
   parameter int IDX_W           = $clog2(NUM_PHYS_REGS),
   parameter int NUM_SRCS        = 4,
   parameter int NUM_WRITE_PORTS = 2,
   parameter int BUF_DEPTH       = 2
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [NUM_SRCS-1:0]                           fu_valid,
   output logic [NUM_SRCS-1:0]                           fu_ready,
   input  logic [NUM_SRCS-1:0][IDX_W-1:0]                fu_index,
   input  logic [NUM_SRCS-1:0][WORD_SIZE-1:0]            fu_data,
   output reg_pkg::RegFileWritePort [NUM_WRITE_PORTS-1:0] write_ports,
   output logic                                          busy
);
   localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

   logic [SRC_W-1:0]                   rr_ptr_q, rr_ptr_d;
   logic [NUM_SRCS-1:0]                empty, full, push, pop, xfer, elig, grant;
   logic [NUM_SRCS-1:0][IDX_W-1:0]     head_idx, cand_idx;
   logic [NUM_SRCS-1:0][WORD_SIZE-1:0] head_data, cand_data;

   // Ready comes only from registered occupancy, held low while in reset.
   assign fu_ready = rst ? ~full : '0;
   assign xfer     = fu_valid & fu_ready;
   assign busy     = |(~empty);

   for (genvar i = 0; i < NUM_SRCS; i++) begin : g_src
      reg_wb_src_fifo #(
         .IDX_W     (IDX_W),
         .WORD_SIZE (WORD_SIZE),
         .DEPTH     (BUF_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[i]),
         .push_idx  (fu_index[i]),
         .push_data (fu_data[i]),
         .pop       (pop[i]),
         .empty     (empty[i]),
         .full      (full[i]),
         .head_idx  (head_idx[i]),
         .head_data (head_data[i])
      );
   end

   // Per-source candidate: buffered head, or the live input when bypass applies.
   always_comb begin
      elig      = '0;
      cand_idx  = '0;
      cand_data = '0;
      for (int i = 0; i < NUM_SRCS; i++) begin
`ifdef REG_WB_BYPASS_EN
         elig[i]      = ~empty[i] | xfer[i];
         cand_idx[i]  = empty[i] ? fu_index[i] : head_idx[i];
         cand_data[i] = empty[i] ? fu_data[i]  : head_data[i];
`else
         elig[i]      = ~empty[i];
         cand_idx[i]  = head_idx[i];
         cand_data[i] = head_data[i];
`endif
      end
   end

   // Round-robin scan from rr_ptr; eligible candidates fill ports in scan
   // order, and a candidate whose index is already granted this cycle waits.
   always_comb begin
      int               nport;
      int               sum;
      logic [SRC_W-1:0] s;
      logic             dup;
      write_ports = '0;
      grant       = '0;
      rr_ptr_d    = rr_ptr_q;
      nport       = 0;
      for (int k = 0; k < NUM_SRCS; k++) begin
         sum = int'(rr_ptr_q) + k;
         if (sum >= NUM_SRCS) sum = sum - NUM_SRCS;
         s   = SRC_W'(sum);
         dup = 1'b0;
         for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
            if (j < nport && write_ports[j].index_in == cand_idx[s]) dup = 1'b1;
         end
         if (elig[s] && !dup && nport < NUM_WRITE_PORTS) begin
            for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
               if (j == nport) begin
                  write_ports[j].en       = 1'b1;
                  write_ports[j].index_in = cand_idx[s];
                  write_ports[j].data_in  = cand_data[s];
               end
            end
            grant[s] = 1'b1;
            rr_ptr_d = (sum == NUM_SRCS - 1) ? '0 : SRC_W'(sum + 1);
            nport    = nport + 1;
         end
      end
   end

   // A granted buffered head pops; a granted bypass entry is never buffered.
   assign pop = grant & ~empty;
`ifdef REG_WB_BYPASS_EN
   assign push = xfer & ~(grant & empty);
`else
   assign push = xfer;
`endif

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rr_ptr_q <= '0;
      else      rr_ptr_q <= rr_ptr_d;
   end
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed scenario tasks plus a per-source
// scoreboard filled at handshake and drained as writes appear on the ports.
`timescale 1ns/1ps
module tb_reg_writeback_arbiter;
   import reg_pkg::*;
   localparam int NS  = 4;
   localparam int NWP = 2;
   localparam int IW  = reg_pkg::IDX_W;
   localparam int WW  = reg_pkg::WORD_SIZE;
   localparam int NI  = 12;
`ifdef REG_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [WW-1:0] data;
   } ent_t;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic [NS-1:0]            fu_valid = '0;
   logic [NS-1:0]            fu_ready;
   logic [NS-1:0][IW-1:0]    fu_index = '0;
   logic [NS-1:0][WW-1:0]    fu_data = '0;
   RegFileWritePort [NWP-1:0] write_ports;
   logic                     busy;

   int   n_vec = 0;
   int   n_err = 0;
   ent_t sbq [NS][$];
   int   sent [NS];
   bit   acc [NS];

   always #5 clk = ~clk;

   reg_writeback_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .fu_valid    (fu_valid),
      .fu_ready    (fu_ready),
      .fu_index    (fu_index),
      .fu_data     (fu_data),
      .write_ports (write_ports),
      .busy        (busy)
   );

   function automatic RegFileWritePort mk(input logic en, input int idx, input logic [WW-1:0] data);
      RegFileWritePort p;
      p.en       = en;
      p.index_in = IW'(idx);
      p.data_in  = data;
      return p;
   endfunction

   // Scoreboard: record accepted inputs, then match every write to a source head.
   always @(negedge clk) begin : mon
      bit   hit;
      ent_t e;
      for (int i = 0; i < NS; i++) begin
         if (fu_valid[i] && fu_ready[i]) begin
            e.idx  = fu_index[i];
            e.data = fu_data[i];
            sbq[i].push_back(e);
         end
      end
      for (int p = 0; p < NWP; p++) begin
         n_vec++;
         if (write_ports[p].en) begin
            hit = 1'b0;
            for (int i = 0; i < NS; i++) begin
               if (!hit && sbq[i].size() > 0 && sbq[i][0].idx == write_ports[p].index_in &&
                   sbq[i][0].data == write_ports[p].data_in) begin
                  hit = 1'b1;
                  void'(sbq[i].pop_front());
               end
            end
            if (!hit) begin
               n_err++;
               $display("FAIL sb_write port%0d: got idx %0d data %h, required a pending source head", p,
                        write_ports[p].index_in, write_ports[p].data_in);
            end
         end else if (write_ports[p].index_in !== '0 || write_ports[p].data_in !== '0) begin
            n_err++;
            $display("FAIL idle_port%0d: got idx %0d data %h, required zeros", p,
                     write_ports[p].index_in, write_ports[p].data_in);
         end
      end
      if (write_ports[0].en && write_ports[1].en) begin
         n_vec++;
         if (write_ports[0].index_in === write_ports[1].index_in) begin
            n_err++;
            $display("FAIL same_idx_cycle: both ports idx %0d, required distinct", write_ports[0].index_in);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Move to the cycle where the first result of the presented inputs shows.
   task automatic to_out();
      if (BYP) @(negedge clk);
      else begin
         tick();
         fu_valid = '0;
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      fu_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < NS; i++) sbq[i].delete();
   endtask

   // One streaming cycle: advance accepted sources, present next item, sample handshake.
   task automatic stream_cycle(input logic [7:0] tag, input logic [NS-1:0] mask);
      for (int i = 0; i < NS; i++) begin
         if (acc[i]) sent[i]++;
         acc[i]      = 1'b0;
         fu_valid[i] = mask[i] && (sent[i] < NI);
         fu_index[i] = IW'(i * 16 + (sent[i] % 16));
         fu_data[i]  = {tag, 8'(i), 16'(sent[i])};
      end
      @(negedge clk);
      for (int i = 0; i < NS; i++) acc[i] = fu_valid[i] && fu_ready[i];
      tick();
   endtask

   task automatic test_reset();
      #2;
      n_vec++; if (fu_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b required 0000", fu_ready); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_vec++; if (write_ports !== '0) begin n_err++; $display("FAIL reset_ports: got %h required 0", write_ports); end
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_vec++; if (fu_ready !== 4'b1111) begin n_err++; $display("FAIL release_ready: got %b required 1111", fu_ready); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy: got %b required 0", busy); end
      tick();
   endtask

   task automatic test_single();
      fu_valid = 4'b0100; fu_index[2] = IW'(5); fu_data[2] = 32'hDEAD;
      to_out();
      n_vec++; if (write_ports[0] !== mk(1, 5, 32'hDEAD)) begin n_err++; $display("FAIL single_p0: got %h required %h", write_ports[0], mk(1, 5, 32'hDEAD)); end
      n_vec++; if (write_ports[1] !== mk(0, 0, 0)) begin n_err++; $display("FAIL single_p1: got %h required %h", write_ports[1], mk(0, 0, 0)); end
      tick();
      // rr_ptr is now 3: source 3 must take port 0 ahead of source 0
      fu_valid = 4'b1001;
      fu_index[0] = IW'(10); fu_data[0] = 32'h100;
      fu_index[3] = IW'(11); fu_data[3] = 32'h300;
      to_out();
      n_vec++; if (write_ports[0] !== mk(1, 11, 32'h300)) begin n_err++; $display("FAIL rr_p0: got %h required %h", write_ports[0], mk(1, 11, 32'h300)); end
      n_vec++; if (write_ports[1] !== mk(1, 10, 32'h100)) begin n_err++; $display("FAIL rr_p1: got %h required %h", write_ports[1], mk(1, 10, 32'h100)); end
      tick();
      fu_valid = '0;
      tick();
   endtask

   task automatic test_four_sources();
      fu_valid = 4'b1111;
      for (int i = 0; i < NS; i++) begin
         fu_index[i] = IW'(i + 1);
         fu_data[i]  = WW'((i + 1) * 32'h11);
      end
      to_out();
      n_vec++; if (write_ports[0] !== mk(1, 1, 32'h11)) begin n_err++; $display("FAIL four_c1_p0: got %h required %h", write_ports[0], mk(1, 1, 32'h11)); end
      n_vec++; if (write_ports[1] !== mk(1, 2, 32'h22)) begin n_err++; $display("FAIL four_c1_p1: got %h required %h", write_ports[1], mk(1, 2, 32'h22)); end
      tick();
      fu_valid = '0;
      @(negedge clk);
      n_vec++; if (write_ports[0] !== mk(1, 3, 32'h33)) begin n_err++; $display("FAIL four_c2_p0: got %h required %h", write_ports[0], mk(1, 3, 32'h33)); end
      n_vec++; if (write_ports[1] !== mk(1, 4, 32'h44)) begin n_err++; $display("FAIL four_c2_p1: got %h required %h", write_ports[1], mk(1, 4, 32'h44)); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL four_c2_busy: got %b required 1", busy); end
      tick();
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL four_c3_busy: got %b required 0", busy); end
      n_vec++; if (write_ports[0].en !== 1'b0) begin n_err++; $display("FAIL four_c3_en: got %b required 0", write_ports[0].en); end
      tick();
   endtask

   task automatic test_same_index();
      fu_valid = 4'b0011;
      fu_index[0] = IW'(7); fu_data[0] = 32'hA;
      fu_index[1] = IW'(7); fu_data[1] = 32'hB;
      to_out();
      n_vec++; if (write_ports[0] !== mk(1, 7, 32'hA)) begin n_err++; $display("FAIL same_c1_p0: got %h required %h", write_ports[0], mk(1, 7, 32'hA)); end
      n_vec++; if (write_ports[1] !== mk(0, 0, 0)) begin n_err++; $display("FAIL same_c1_p1: got %h required %h", write_ports[1], mk(0, 0, 0)); end
      tick();
      fu_valid = '0;
      @(negedge clk);
      n_vec++; if (write_ports[0] !== mk(1, 7, 32'hB)) begin n_err++; $display("FAIL same_c2_p0: got %h required %h", write_ports[0], mk(1, 7, 32'hB)); end
      n_vec++; if (write_ports[1].en !== 1'b0) begin n_err++; $display("FAIL same_c2_p1: got en %b required 0", write_ports[1].en); end
      tick();
      tick();
   endtask

   task automatic test_backpressure();
      bit saw_full0;
      bit done;
      int pending;
      saw_full0 = 1'b0;
      done = 1'b0;
      for (int i = 0; i < NS; i++) begin sent[i] = 0; acc[i] = 1'b0; end
      for (int c = 0; c < 200 && !done; c++) begin
         stream_cycle(8'hB0, 4'b1111);
         if (fu_valid[0] && !acc[0]) saw_full0 = 1'b1;
         done = 1'b1;
         for (int i = 0; i < NS; i++) if (sent[i] + int'(acc[i]) < NI) done = 1'b0;
      end
      fu_valid = '0;
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_budget: got done %b required 1", done); end
      n_vec++; if (saw_full0 !== 1'b1) begin n_err++; $display("FAIL bp_ready0_drop: got %b required 1", saw_full0); end
      for (int c = 0; c < 20 && busy; c++) tick();
      @(negedge clk);
      pending = 0;
      for (int i = 0; i < NS; i++) pending += sbq[i].size();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_drain_busy: got %b required 0", busy); end
      n_vec++; if (pending !== 0) begin n_err++; $display("FAIL bp_lost: got %0d pending required 0", pending); end
      tick();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < NS; i++) begin sent[i] = 0; acc[i] = 1'b0; end
      for (int c = 0; c < 6; c++) stream_cycle(8'hE0, 4'b1111);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ar_busy_before: got %b required 1", busy); end
      #2;
      rst = 1'b0;
      #1;
      n_vec++; if (write_ports[0].en !== 1'b0 || write_ports[1].en !== 1'b0) begin n_err++; $display("FAIL ar_en_async: got %b%b required 00", write_ports[1].en, write_ports[0].en); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy_async: got %b required 0", busy); end
      n_vec++; if (fu_ready !== 4'b0000) begin n_err++; $display("FAIL ar_ready_async: got %b required 0000", fu_ready); end
      for (int i = 0; i < NS; i++) sbq[i].delete();
      fu_valid = '0;
      tick();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_vec++; if (write_ports[0].en !== 1'b0 || write_ports[1].en !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL ar_stale c%0d: got en %b%b busy %b required 00 0", c, write_ports[1].en, write_ports[0].en, busy);
         end
         tick();
      end
      fu_valid = 4'b0010; fu_index[1] = IW'(9); fu_data[1] = 32'h99;
      to_out();
      n_vec++; if (write_ports[0] !== mk(1, 9, 32'h99)) begin n_err++; $display("FAIL ar_after_p0: got %h required %h", write_ports[0], mk(1, 9, 32'h99)); end
      tick();
      fu_valid = '0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      do_reset();
      test_four_sources();
      do_reset();
      test_same_index();
      test_backpressure();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Producer side of the physical register file write interface.
- Collects completed results from NUM_SRCS functional units over valid/ready handshakes and buffers each source in a small per-source FIFO.
- Each cycle it grants up to NUM_WRITE_PORTS buffered results round-robin and drives them onto the register file's RegFileWritePort array.
- Sits between execute-stage completion and the physical register file.

Parameters:
- WORD_SIZE, reg_pkg::WORD_SIZE, result data width.
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS, physical register count; IDX_W = $clog2(NUM_PHYS_REGS).
- NUM_SRCS, 4, number of functional-unit result sources.
- NUM_WRITE_PORTS, 2, register file write ports driven; must be <= NUM_SRCS.
- BUF_DEPTH, 2, entries per source FIFO; power of two, >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- fu_valid  in  [NUM_SRCS] x 1  source i presents a result.
- fu_ready  out  [NUM_SRCS] x 1  source i's buffer can accept.
- fu_index  in  [NUM_SRCS] x IDX_W  destination physical register.
- fu_data  in  [NUM_SRCS] x WORD_SIZE  result value.
- write_ports  out  [NUM_WRITE_PORTS] x RegFileWritePort  fields en, index_in, data_in; feeds the register file.
- busy  out  1  any source buffer non-empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFOs emptied; rr_ptr = 0.
  - All write_ports en = 0, index_in = 0, data_in = 0.
  - fu_ready = 0 while rst is asserted; busy = 0.
  - Reset mid-operation discards all buffered results.
- Accept:
  - fu_ready[i] = (registered count[i] < BUF_DEPTH); it has no combinational dependence on fu_valid or on the current cycle's grants.
  - Transfer occurs when fu_valid[i] && fu_ready[i] at the rising edge; the entry is pushed at the FIFO tail.
  - A source holds valid/index/data stable until the transfer.
- Eligibility: source i is eligible when its FIFO is non-empty; only the head entry is eligible.
- Grant:
  - Scan sources starting at rr_ptr, wrapping modulo NUM_SRCS.
  - The first eligible source goes to port 0, the next to port 1, and so on, up to NUM_WRITE_PORTS.
  - Same-index rule: an eligible head whose index equals an index already granted this cycle is skipped; it stays buffered and retries next cycle.
  - Unused ports drive en = 0, index_in = 0, data_in = 0.
- Outputs: write_ports are combinational from FIFO heads and the grant. A granted head pops at the rising edge.
- Round-robin pointer: if any grant occurs, rr_ptr <= (last granted source + 1) mod NUM_SRCS; otherwise it holds.
- Simultaneous push and pop on one source in one cycle: count unchanged, order preserved.
- Latency without bypass: handshake at edge N -> write_ports en in cycle N+1 -> register written at edge N+1 (best case).
- Per-source ordering: results from one source are written in arrival order.
- Cross-source ordering: not guaranteed.
- Full: count == BUF_DEPTH drops fu_ready the cycle after the fill. Pointers wrap at BUF_DEPTH.
- busy = OR of FIFO non-empty flags, from registered state.

Optional Feature:
- Macro REG_WB_BYPASS_EN.
- Defined: a source whose FIFO is empty and whose fu_valid && fu_ready holds this cycle is eligible this cycle with the input entry.
  - If granted, the entry is not pushed: zero-cycle latency, register written at the same edge as the handshake.
  - If not granted, it is pushed normally.
- Undefined: inputs are always pushed first; minimum latency is one cycle.
- fu_ready is unaffected in both cases.

Test Plan:
- Reset release, idle inputs -> all en = 0, busy = 0; the cycle after rst = 1, fu_ready = 4'b1111.
- Single result: src 2, index 5, data 0xDEAD at edge N -> cycle N+1 port0 {en 1, idx 5, 0xDEAD}; rr_ptr = 3 after edge N+1.
- Four sources valid in one cycle (idx 1,2,3,4), rr_ptr = 0 -> next cycle ports {1,2}, then {3,4}; busy drops after the second drain.
- Same index: src0 and src1 both target idx 7 (0xA, 0xB), rr_ptr = 0 -> cycle 1 port0 = {7, 0xA}, port1 en = 0; cycle 2 port0 = {7, 0xB}.
- Backpressure: src0 valid every cycle while the other three sources also stream, BUF_DEPTH = 2 -> fu_ready[0] deasserts when count = 2; no loss, per-source order preserved (checked by scoreboard).
- Async reset asserted mid-burst with buffers full -> en = 0 immediately without a clock edge; after release busy = 0 and no stale writes appear.
